// File: rtl/mod_sram32k_ctrl.sv
// Single-beat initiator for a 32K x 8 asynchronous SRAM: sequences CS_N/OE_N/WE_N
// with programmable wait states and returns read data with a one-cycle strobe.
module mod_sram32k_ctrl #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0] sram_a_o,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe_o,
  output logic              sram_cs_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + TURN_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RD_WAIT,
    S_WR_PULSE,
    S_WR_HOLD,
    S_TURN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic              dq_oe_q, dq_oe_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  // Next state, then pin levels decoded from the state being entered so every pin is a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    a_d         = a_q;
    dq_d        = dq_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    ready_d     = 1'b0;
    dq_oe_d     = 1'b0;
    cs_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d = S_SETUP;
          we_d    = req_we_i;
          a_d     = req_addr_i;
          if (req_we_i) dq_d = req_wdata_i;
        end
      end
      S_SETUP: begin
        state_d = we_q ? S_WR_PULSE : S_RD_WAIT;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_TURN;
          cnt_d       = CNT_W'(TURN_CYCLES - 1);
          rdata_d     = sram_dq_i;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      S_IDLE:     ready_d = 1'b1;
      S_SETUP: begin
        cs_n_d = 1'b0;
        if (we_d) dq_oe_d = 1'b1;
        else      oe_n_d  = 1'b0;
      end
      S_RD_WAIT: begin
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_WR_PULSE: begin
        cs_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_WR_HOLD: begin
        cs_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      a_q         <= '0;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      a_q         <= a_d;
      dq_q        <= dq_d;
      dq_oe_q     <= dq_oe_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign sram_a_o     = a_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_cs_n_o  = cs_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;

endmodule

// File: tb/tb_mod_sram32k_ctrl.sv
// Bench for mod_sram32k_ctrl: behavioural async SRAM, shadow memory and per-cycle pin-timing windows.
module tb_mod_sram32k_ctrl;

  localparam int W = 2;
  localparam int T = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [14:0] sram_a;
  logic [7:0]  sram_dq_out;
  logic [7:0]  sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_cs_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int checks;
  int errors;
  int inv_viol;
  int acc_cnt;
  int rsp_cnt;

  logic [7:0] mem     [0:32767];
  logic [7:0] exp_mem [0:32767];

  mod_sram32k_ctrl #(
    .ADDR_W(15), .DATA_W(8), .WAIT_CYCLES(W), .TURN_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .sram_a_o     (sram_a),
    .sram_dq_o    (sram_dq_out),
    .sram_dq_i    (sram_dq_in),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_cs_n_o  (sram_cs_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5B);
  endfunction

  // Async SRAM: data out while selected and output-enabled, write latched on WE_N rising.
  assign sram_dq_in = (!sram_cs_n && !sram_oe_n && !sram_dq_oe) ? mem[sram_a] : 8'hxx;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
    #1;
    forever begin
      @(posedge sram_we_n);
      if (!sram_cs_n) mem[sram_a] = sram_dq_out;
    end
  end

  // Bus-protocol watchdog sampled mid-cycle.
  logic        prev_cs_n;
  logic [14:0] prev_a;
  logic [7:0]  prev_dq;
  initial begin
    inv_viol = 0; acc_cnt = 0; rsp_cnt = 0; prev_cs_n = 1'b1; prev_a = '0; prev_dq = '0;
    forever begin
      @(negedge clk);
      if (!sram_oe_n && !sram_we_n) begin
        inv_viol++; $display("FAIL inv_oe_we t=%0t both low", $time);
      end
      if (sram_dq_oe && !sram_oe_n) begin
        inv_viol++; $display("FAIL inv_contention t=%0t dq_oe=1 oe_n=0", $time);
      end
      if (!sram_we_n && sram_cs_n) begin
        inv_viol++; $display("FAIL inv_we_cs t=%0t we_n=0 cs_n=1", $time);
      end
      if (!sram_cs_n && !prev_cs_n && (sram_a !== prev_a || sram_dq_out !== prev_dq)) begin
        inv_viol++; $display("FAIL inv_stable t=%0t a=%h/%h dq=%h/%h", $time, sram_a, prev_a, sram_dq_out, prev_dq);
      end
      if (!sram_cs_n && prev_cs_n) acc_cnt++;
      if (rsp_valid) rsp_cnt++;
      prev_cs_n = sram_cs_n; prev_a = sram_a; prev_dq = sram_dq_out;
    end
  end

  task automatic issue(input logic we, input logic [14:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!req_ready) begin
      errors++; $display("FAIL handshake_timeout got ready=%b exp=1", req_ready);
    end
    @(posedge clk);
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [7:0] data, input bit pulse);
    logic [7:0] cs_m, we_m, oe_m, rdy_m, cs_e, we_e, oe_e, rdy_e;
    int acc0;
    cs_m = '0; we_m = '0; oe_m = '0; rdy_m = '0;
    cs_e = '0; we_e = '0; oe_e = '0; rdy_e = '0;
    for (int k = 1; k < 8; k++) begin
      cs_e[k]  = (k <= 2 + W);
      we_e[k]  = (k >= 2 && k <= 1 + W);
      oe_e[k]  = (k <= 2 + W);
      rdy_e[k] = (k >= 3 + W);
    end
    acc0 = acc_cnt;
    issue(1'b1, addr, data);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 15'($urandom); req_wdata = 8'($urandom);
      end
      if (pulse && k == 2) req_valid = 1'b1;
      if (pulse && k == 3) req_valid = 1'b0;
      cs_m[k] = ~sram_cs_n; we_m[k] = ~sram_we_n; oe_m[k] = sram_dq_oe; rdy_m[k] = req_ready;
    end
    checks++; if (cs_m !== cs_e) begin errors++; $display("FAIL wr_cs_window a=%h got=%b exp=%b", addr, cs_m, cs_e); end
    checks++; if (we_m !== we_e) begin errors++; $display("FAIL wr_we_window a=%h got=%b exp=%b", addr, we_m, we_e); end
    checks++; if (oe_m !== oe_e) begin errors++; $display("FAIL wr_dqoe_window a=%h got=%b exp=%b", addr, oe_m, oe_e); end
    checks++; if (rdy_m !== rdy_e) begin errors++; $display("FAIL wr_ready_window a=%h got=%b exp=%b", addr, rdy_m, rdy_e); end
    exp_mem[addr] = data;
    checks++; if (mem[addr] !== data) begin errors++; $display("FAIL wr_data a=%h got=%h exp=%h", addr, mem[addr], data); end
    checks++; if (acc_cnt - acc0 != 1) begin errors++; $display("FAIL wr_access_count got=%0d exp=1", acc_cnt - acc0); end
  endtask

  task automatic do_read(input logic [14:0] addr);
    logic [7:0] oe_m, rsp_m, rdy_m, oe_e, rsp_e, rdy_e;
    int acc0;
    oe_m = '0; rsp_m = '0; rdy_m = '0; oe_e = '0; rsp_e = '0; rdy_e = '0;
    for (int k = 1; k < 8; k++) begin
      oe_e[k]  = (k <= 1 + W);
      rsp_e[k] = (k == 2 + W);
      rdy_e[k] = (k >= 2 + W + T);
    end
    acc0 = acc_cnt;
    issue(1'b0, addr, 8'h00);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_we = 1'b1; req_addr = 15'($urandom); req_wdata = 8'($urandom);
      end
      oe_m[k] = ~sram_oe_n; rsp_m[k] = rsp_valid; rdy_m[k] = req_ready;
    end
    checks++; if (oe_m !== oe_e) begin errors++; $display("FAIL rd_oe_window a=%h got=%b exp=%b", addr, oe_m, oe_e); end
    checks++; if (rsp_m !== rsp_e) begin errors++; $display("FAIL rd_rsp_window a=%h got=%b exp=%b", addr, rsp_m, rsp_e); end
    checks++; if (rdy_m !== rdy_e) begin errors++; $display("FAIL rd_ready_window a=%h got=%b exp=%b", addr, rdy_m, rdy_e); end
    checks++; if (rsp_rdata !== exp_mem[addr]) begin errors++; $display("FAIL rd_data a=%h got=%h exp=%h", addr, rsp_rdata, exp_mem[addr]); end
    checks++; if (acc_cnt - acc0 != 1) begin errors++; $display("FAIL rd_access_count got=%0d exp=1", acc_cnt - acc0); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, rsp_valid} !== 5'b11100) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=11100", {sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, rsp_valid});
    end
    checks++;
    if ({sram_a, sram_dq_out, rsp_rdata} !== 31'h0) begin
      errors++; $display("FAIL reset_data got a=%h dq=%h rd=%h exp 0", sram_a, sram_dq_out, rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] a1, a2;
    logic [7:0]  d2, cap;
    int n;
    a1 = 15'($urandom); a2 = 15'($urandom); d2 = 8'($urandom); cap = 8'h00;
    issue(1'b0, a1, 8'h00);
    @(negedge clk);
    req_we = 1'b1; req_addr = a2; req_wdata = d2;
    n = 1;
    while (!req_ready && n < 20) begin
      @(negedge clk); n++;
      if (rsp_valid) cap = rsp_rdata;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (n < 4) begin errors++; $display("FAIL b2b_min_gap got=%0d exp>=4", n); end
    checks++; if (n != 2 + W + T) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", n, 2 + W + T); end
    checks++; if (cap !== exp_mem[a1]) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", cap, exp_mem[a1]); end
    repeat (6) @(negedge clk);
    exp_mem[a2] = d2;
    checks++; if (mem[a2] !== d2) begin errors++; $display("FAIL b2b_wdata got=%h exp=%h", mem[a2], d2); end
  endtask

  task automatic test_reset_mid();
    int rsp0;
    issue(1'b0, 15'h0100, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    rsp0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_cs_n, sram_oe_n} !== 2'b11) begin
      errors++; $display("FAIL midrst_ctrl got=%b exp=11", {sram_cs_n, sram_oe_n});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rsp_cnt != rsp0) begin errors++; $display("FAIL midrst_rsp got=%0d exp=0", rsp_cnt - rsp0); end
    do_read(15'h0001);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [14:0] a;
      a = 15'($urandom);
      if (i % 4 == 3) a = 15'h7FF0 | 15'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), 1'($urandom));
      else do_read(a);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 32768; i++) exp_mem[i] = init_val(i);
    test_reset();
    do_write(15'h1234, 8'hA5, 1'b0);
    do_read(15'h1234);
    test_back_to_back();
    test_reset_mid();
    do_write(15'h7FFF, 8'h3C, 1'b1);
    do_read(15'h7FFF);
    do_read(15'h0000);
    test_random();
    repeat (4) @(negedge clk);
    checks++; if (inv_viol != 0) begin errors++; $display("FAIL bus_invariants got=%0d exp=0", inv_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_sram32k_ctrl.md
Name: mod_sram32k_ctrl

Overview:
Synchronous initiator for the 32K x 8 asynchronous SRAM (active-low CS/OE/WE, 12 ns access, shared 8-bit data bus). Accepts single-beat read/write requests over a valid/ready handshake from the hash core. Sequences chip-select, output-enable and write-enable with programmable wait states. Returns read data with a one-cycle response strobe. Drives the bidirectional bus through split out/in/enable signals; the tristate buffer sits in the top-level pad wrapper.

Parameters:
ADDR_W, 15, SRAM address width
DATA_W, 8, SRAM data width
WAIT_CYCLES, 2, CLK cycles WE_N pulse / read access lasts (>=1; must cover 12 ns)
TURN_CYCLES, 1, bus-turnaround idle cycles after every read (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  controller can accept; high only in IDLE
REQ_WE  in  1  1=write, 0=read
REQ_ADDR  in  ADDR_W  request address
REQ_WDATA  in  DATA_W  write data
RSP_VALID  out  1  one-cycle read-data strobe
RSP_RDATA  out  DATA_W  read data, held until next read
SRAM_A  out  ADDR_W  SRAM address
SRAM_DQ_OUT  out  DATA_W  data driven to SRAM
SRAM_DQ_IN  in  DATA_W  data sampled from SRAM bus
SRAM_DQ_OE  out  1  1=controller drives bus
SRAM_CS_N  out  1  chip select, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_WE_N  out  1  write enable, active low

Behaviour:
- Reset (async, immediate): state IDLE; SRAM_CS_N=SRAM_OE_N=SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_A=0, SRAM_DQ_OUT=0, RSP_VALID=0, RSP_RDATA=0, counter=0. REQ_READY=1 once RST_N deasserts.
- All outputs are registered, or decoded only from the state register. No combinational path from REQ_* to SRAM_*.
- Handshake: a transfer occurs on a rising edge with REQ_VALID && REQ_READY. REQ_WE/ADDR/WDATA are latched then; later changes are ignored. REQ_VALID while not ready is ignored and not queued.
- States: IDLE, SETUP, RD_WAIT, WR_PULSE, WR_HOLD, TURN.
- IDLE: controls high, DQ_OE=0. On handshake -> SETUP with SRAM_A=REQ_ADDR.
- Read path:
  - SETUP (1 cycle): CS_N=0, OE_N=0, DQ_OE=0. Then RD_WAIT.
  - RD_WAIT (WAIT_CYCLES cycles): CS_N=0, OE_N=0. At the edge ending the last wait cycle, RSP_RDATA<=SRAM_DQ_IN and the state goes to TURN.
  - TURN (TURN_CYCLES cycles): CS_N=OE_N=1, DQ_OE=0. RSP_VALID=1 in the first TURN cycle only. Then IDLE.
  - Handshake to RSP_VALID = 1+WAIT_CYCLES cycles. Occupancy = 1+WAIT_CYCLES+TURN_CYCLES cycles.
- Write path:
  - SETUP (1 cycle): CS_N=0, WE_N=1, OE_N=1, DQ_OE=1, DQ_OUT=latched data.
  - WR_PULSE (WAIT_CYCLES cycles): WE_N=0.
  - WR_HOLD (1 cycle): WE_N=1, CS_N=0; A and DQ held. Then IDLE with DQ_OE=0.
  - Occupancy = 2+WAIT_CYCLES cycles. No RSP_VALID for writes.
- Invariants, all checked every cycle:
  - OE_N and WE_N are never both 0.
  - DQ_OE=1 never coincides with OE_N=0.
  - WE_N=0 only when CS_N=0.
  - SRAM_A and DQ_OUT are stable whenever CS_N=0.
- Address: full ADDR_W range, no wrap or increment; 0x7FFF is a legal address.
- Wait counter: $clog2(WAIT_CYCLES+TURN_CYCLES)+1 bits; it reloads on each state entry.
- Reset mid-operation: the in-flight access is abandoned, no RSP_VALID, and the SRAM contents at the target address are undefined for writes. The first request after reset completes normally.

Test Plan:
1. Assert RST_N=0 mid-idle -> all SRAM controls 1, DQ_OE=0, RSP_VALID=0, REQ_READY=1 after release.
2. Write A=0x1234 D=0xA5, WAIT=2 -> CS_N low for exactly 4 cycles. WE_N low for exactly cycles 2-3. DQ_OE=1 cycles 1-4. REQ_READY high again in cycle 5.
3. Read A=0x1234 against the SRAM behavioural model -> RSP_VALID high exactly 3 cycles after the handshake, RSP_RDATA=0xA5, OE_N low for 3 cycles.
4. Read then write back-to-back with REQ_VALID held high -> write handshake no earlier than 4 cycles after the read handshake. DQ_OE never 1 while OE_N=0. Model never sees bus contention (no X on IO).
5. Pull RST_N low during RD_WAIT -> CS_N/OE_N go high in the same timestep, no RSP_VALID. A subsequent read of 0x0001 returns the model value.
6. Write 0x3C to 0x7FFF, then read 0x7FFF and 0x0000 -> 0x3C and the untouched value. A pulse on REQ_VALID while REQ_READY=0 produces no extra access.
